// File: rtl/cla_pipe_adder_if.sv
// Operand/result handshake bundle for the pipelined CLA adder.
// Latency: none (wires only).
// Backpressure: in_ready/out_ready carry the stall in each direction.
interface cla_pipe_adder_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;

  // Producer/consumer side (drives operands, accepts results)
  modport master (
    output in_valid, in_a, in_b, in_cin, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf
  );

  // Adder side
  modport slave (
    input  in_valid, in_a, in_b, in_cin, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf
  );
endinterface

// File: rtl/cla_pipe_adder.sv
// Pipelined WIDTH-bit adder resolving one 4-bit carry-lookahead slice per stage.
// Latency: WIDTH/SLICE cycles from accept edge to out_valid; one beat per cycle.
// Backpressure: whole pipe freezes when out_valid & !out_ready; in_ready = advance.
module cla_pipe_adder #(
  parameter int WIDTH = 32,
  parameter int SLICE = 4
) (
  input logic               clk,
  input logic               rst_n,
  cla_pipe_adder_if.slave   bus
);

  localparam int STAGES = WIDTH / SLICE;

  // One CLA slice in generate/propagate form; the carry recurrence unrolls
  // into flat lookahead terms, so each stage has a single slice of depth.
  function automatic logic [SLICE:0] cla_slice(
    input logic [SLICE-1:0] a,
    input logic [SLICE-1:0] b,
    input logic             ci
  );
    logic [SLICE-1:0] g;
    logic [SLICE-1:0] p;
    logic [SLICE:0]   c;
    g    = a & b;
    p    = a ^ b;
    c    = '0;
    c[0] = ci;
    for (int i = 0; i < SLICE; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
    return {c[SLICE], p ^ c[SLICE-1:0]};
  endfunction

  // Global advance: every stage moves together or nothing moves, so a stall
  // never collapses bubbles and the output registers stay stable.
  logic adv;
  assign adv          = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int IW  = WIDTH - SLICE * k;    // operand bits not yet resolved entering stage k
    localparam int REM = IW - SLICE;           // operand bits still pending after stage k
    localparam int SW  = SLICE * (k + 1);      // sum bits resolved once stage k is done

    logic           vld_in;
    logic           cy_in;
    logic [IW-1:0]  a_in;
    logic [IW-1:0]  b_in;
    logic [SLICE:0] res;
    logic [SW-1:0]  sum_d;
    logic           vld_q;
    logic           cy_q;
    logic [SW-1:0]  sum_q;

    if (k == 0) begin : g_first
      assign vld_in = bus.in_valid;
      assign cy_in  = bus.in_cin;
      assign a_in   = bus.in_a;
      assign b_in   = bus.in_b;
      assign sum_d  = res[SLICE-1:0];
    end else begin : g_next
      assign vld_in = g_stage[k-1].vld_q;
      assign cy_in  = g_stage[k-1].cy_q;
      assign a_in   = g_stage[k-1].g_ops.a_q;
      assign b_in   = g_stage[k-1].g_ops.b_q;
      assign sum_d  = {res[SLICE-1:0], g_stage[k-1].sum_q};
    end

    assign res = cla_slice(a_in[SLICE-1:0], b_in[SLICE-1:0], cy_in);

    // Stage valid, slice carry-out and accumulated low sum bits
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        vld_q <= 1'b0;
        cy_q  <= 1'b0;
        sum_q <= '0;
      end else if (adv) begin
        vld_q <= vld_in;
        cy_q  <= res[SLICE];
        sum_q <= sum_d;
      end
    end

    if (REM > 0) begin : g_ops
      logic [REM-1:0] a_q;
      logic [REM-1:0] b_q;

      // Carry forward only the operand bits later slices still need
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv) begin
          a_q <= a_in[IW-1:SLICE];
          b_q <= b_in[IW-1:SLICE];
        end
      end
    end else begin : g_last
      logic ovf_d;
      logic ovf_q;

      // a^b^sum at the MSB recovers the carry into bit WIDTH-1
      assign ovf_d = a_in[SLICE-1] ^ b_in[SLICE-1] ^ res[SLICE-1] ^ res[SLICE];

      // Signed-overflow flag, registered alongside the final slice
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (adv) begin
          ovf_q <= ovf_d;
        end
      end
    end
  end

  assign bus.out_valid = g_stage[STAGES-1].vld_q;
  assign bus.out_sum   = g_stage[STAGES-1].sum_q;
  assign bus.out_cout  = g_stage[STAGES-1].cy_q;
  assign bus.out_ovf   = g_stage[STAGES-1].g_last.ovf_q;

endmodule
